// File: rtl/li_expander.sv
// Expands "li rd, imm32" into one or two RISC-V words (LUI and/or ADDI)
// and streams them out over a registered valid/ready interface.
module li_expander #(
  parameter bit OPT_SHORT = 1'b1,
  parameter bit NOP_ON_X0 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] imm_value_i,
  input  logic [4:0]  rd_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        last_o
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addi_q, addi_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        taken;

  // Upper field absorbs the sign of the low 12 bits; the add wraps mod 2^20.
  function automatic logic [19:0] hi_field(input logic [31:0] imm);
    return imm[31:12] + {19'd0, imm[11]};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] hi, input logic [4:0] rd);
    return {hi, rd, 7'h37};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [11:0] lo, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {lo, rs1, 3'b000, rd, 7'h13};
  endfunction

  assign taken = valid_q && instr_ready_i;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addi_d  = addi_q;
    last_d  = last_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = EMIT1;
          valid_d = 1'b1;
          addi_d  = enc_addi(imm_value_i[11:0], rd_i, rd_i);
          if (NOP_ON_X0 && (rd_i == 5'd0)) begin
            instr_d = 32'h0000_0013;
            last_d  = 1'b1;
          end else if (OPT_SHORT && ((&imm_value_i[31:11]) || !(|imm_value_i[31:11]))) begin
            instr_d = enc_addi(imm_value_i[11:0], 5'd0, rd_i);
            last_d  = 1'b1;
          end else if (OPT_SHORT && (imm_value_i[11:0] == 12'd0)) begin
            instr_d = enc_lui(hi_field(imm_value_i), rd_i);
            last_d  = 1'b1;
          end else begin
            instr_d = enc_lui(hi_field(imm_value_i), rd_i);
            last_d  = 1'b0;
          end
        end
      end
      EMIT1: begin
        if (taken) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // Second word follows the first handshake with no bubble.
            state_d = EMIT2;
            instr_d = addi_q;
            last_d  = 1'b1;
          end
        end
      end
      EMIT2: begin
        if (taken) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= 32'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Pending ADDI is pure data; it is always reloaded before use.
  always_ff @(posedge clk) begin
    addi_q <= addi_d;
  end

  assign req_ready_o   = (state_q == IDLE);
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign last_o        = last_q;

endmodule
